sample_sequencer: RTL and testbench

Walks a triangle's bounding box in raster order and emits one sample location per cycle to the downstream sample test stage. It sits between the bounding-box stage (R13) and sample test (R14). The step size is set by the subsample rate. Both sides use the pipeline's active-low halt handshake, and triangles are accepted back-to-back with no bubble.

---
 rtl/sample_sequencer.sv | 131 +++++++++++++
 tb/tb_sample_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sample_sequencer
// Description : Walks a triangle bounding box in raster order, emitting one
//               sample location per cycle toward the sample test stage (R14).
// Revision    : 1.0 - initial release
// ============================================================================
module sample_sequencer #(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [SIGFIG-1:0] tri_R13S    [VERTS-1:0][AXIS-1:0],
    input  logic        [SIGFIG-1:0] color_R13U  [COLORS-1:0],
    input  logic signed [SIGFIG-1:0] box_R13S    [1:0][1:0],
    input  logic                     validTri_R13H,
    input  logic        [3:0]        subSample_RnnnnU,
    input  logic                     halt_RnnnnL,
    output logic                     halt_R13L,
    output logic signed [SIGFIG-1:0] tri_R14S    [VERTS-1:0][AXIS-1:0],
    output logic        [SIGFIG-1:0] color_R14U  [COLORS-1:0],
    output logic signed [SIGFIG-1:0] sample_R14S [1:0],
    output logic                     validSamp_R14H
);

    localparam logic [0:0] c_WAIT = 1'b0;
    localparam logic [0:0] c_TEST = 1'b1;

    localparam logic signed [SIGFIG:0] c_STEP_1   = (SIGFIG+1)'(1 << RADIX);
    localparam logic signed [SIGFIG:0] c_STEP_4   = (SIGFIG+1)'(1 << (RADIX-1));
    localparam logic signed [SIGFIG:0] c_STEP_16  = (SIGFIG+1)'(1 << (RADIX-2));
    localparam logic signed [SIGFIG:0] c_STEP_64  = (SIGFIG+1)'(1 << (RADIX-3));

    logic [0:0]               r_state;
    logic                     r_valid;
    logic signed [SIGFIG-1:0] r_tri   [VERTS-1:0][AXIS-1:0];
    logic        [SIGFIG-1:0] r_color [COLORS-1:0];
    logic signed [SIGFIG-1:0] r_samp_x;
    logic signed [SIGFIG-1:0] r_samp_y;
    logic signed [SIGFIG-1:0] r_ll_x;
    logic signed [SIGFIG-1:0] r_ur_x;
    logic signed [SIGFIG-1:0] r_ur_y;
    logic signed [SIGFIG:0]   r_step;

    logic signed [SIGFIG:0]   w_step_in;
    logic signed [SIGFIG:0]   w_x_ext;
    logic signed [SIGFIG:0]   w_y_ext;
    logic signed [SIGFIG:0]   w_ur_x_ext;
    logic signed [SIGFIG:0]   w_ur_y_ext;
    logic signed [SIGFIG:0]   w_next_x;
    logic signed [SIGFIG:0]   w_next_y;
    logic                     w_x_over;
    logic                     w_y_over;
    logic                     w_at_last;
    logic                     w_accept;

    // Unrecognised subsample codes fall back to one sample per pixel.
    always_comb begin
        w_step_in = c_STEP_1;
        case (subSample_RnnnnU)
            4'b1000: w_step_in = c_STEP_1;
            4'b0100: w_step_in = c_STEP_4;
            4'b0010: w_step_in = c_STEP_16;
            4'b0001: w_step_in = c_STEP_64;
            default: w_step_in = c_STEP_1;
        endcase
    end

    // One extra bit keeps coordinate + step from wrapping near the positive limit.
    assign w_x_ext    = {r_samp_x[SIGFIG-1], r_samp_x};
    assign w_y_ext    = {r_samp_y[SIGFIG-1], r_samp_y};
    assign w_ur_x_ext = {r_ur_x[SIGFIG-1], r_ur_x};
    assign w_ur_y_ext = {r_ur_y[SIGFIG-1], r_ur_y};
    assign w_next_x   = w_x_ext + r_step;
    assign w_next_y   = w_y_ext + r_step;
    assign w_x_over   = (w_next_x > w_ur_x_ext);
    assign w_y_over   = (w_next_y > w_ur_y_ext);
    assign w_at_last  = w_x_over && w_y_over;

    assign halt_R13L = !rst && ((r_state == c_WAIT) ||
                                ((r_state == c_TEST) && w_at_last && halt_RnnnnL));
    assign w_accept  = halt_R13L && validTri_R13H;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_WAIT;
            r_valid  <= 1'b0;
            r_tri    <= '{default: '0};
            r_color  <= '{default: '0};
            r_samp_x <= '0;
            r_samp_y <= '0;
            r_ll_x   <= '0;
            r_ur_x   <= '0;
            r_ur_y   <= '0;
            r_step   <= '0;
        end else if (w_accept) begin
            r_state  <= c_TEST;
            r_valid  <= 1'b1;
            r_tri    <= tri_R13S;
            r_color  <= color_R13U;
            r_samp_x <= box_R13S[0][0];
            r_samp_y <= box_R13S[0][1];
            r_ll_x   <= box_R13S[0][0];
            r_ur_x   <= box_R13S[1][0];
            r_ur_y   <= box_R13S[1][1];
            r_step   <= w_step_in;
        end else if ((r_state == c_TEST) && halt_RnnnnL) begin
            if (w_at_last) begin
                r_state <= c_WAIT;
                r_valid <= 1'b0;
            end else if (!w_x_over) begin
                r_samp_x <= w_next_x[SIGFIG-1:0];
            end else begin
                r_samp_x <= r_ll_x;
                r_samp_y <= w_next_y[SIGFIG-1:0];
            end
        end
    end

    assign tri_R14S       = r_tri;
    assign color_R14U     = r_color;
    assign sample_R14S[0] = r_samp_x;
    assign sample_R14S[1] = r_samp_y;
    assign validSamp_R14H = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_sample_sequencer.sv
`default_nettype none
// Bench for sample_sequencer: directed scenarios plus a randomized triangle
// stream scored against a raster-walk model of the expected sample sequence.
module tb_sample_sequencer;

    localparam int SIGFIG = 24;
    localparam int RADIX  = 10;
    localparam int VERTS  = 3;
    localparam int AXIS   = 3;
    localparam int COLORS = 3;

    logic                     clk = 1'b0;
    logic                     rst;
    logic signed [SIGFIG-1:0] tri_R13S    [VERTS-1:0][AXIS-1:0];
    logic        [SIGFIG-1:0] color_R13U  [COLORS-1:0];
    logic signed [SIGFIG-1:0] box_R13S    [1:0][1:0];
    logic                     validTri_R13H;
    logic        [3:0]        subSample_RnnnnU;
    logic                     halt_RnnnnL;
    logic                     halt_R13L;
    logic signed [SIGFIG-1:0] tri_R14S    [VERTS-1:0][AXIS-1:0];
    logic        [SIGFIG-1:0] color_R14U  [COLORS-1:0];
    logic signed [SIGFIG-1:0] sample_R14S [1:0];
    logic                     validSamp_R14H;

    int n_cmp = 0;
    int n_err = 0;

    sample_sequencer #(
        .SIGFIG(SIGFIG), .RADIX(RADIX), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS)
    ) u_dut (
        .clk              (clk),
        .rst              (rst),
        .tri_R13S         (tri_R13S),
        .color_R13U       (color_R13U),
        .box_R13S         (box_R13S),
        .validTri_R13H    (validTri_R13H),
        .subSample_RnnnnU (subSample_RnnnnU),
        .halt_RnnnnL      (halt_RnnnnL),
        .halt_R13L        (halt_R13L),
        .tri_R14S         (tri_R14S),
        .color_R14U       (color_R14U),
        .sample_R14S      (sample_R14S),
        .validSamp_R14H   (validSamp_R14H)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int tri_val(input int id, input int v, input int a);
        return id * 16 + v * 3 + a;
    endfunction

    function automatic int color_val(input int id, input int c);
        return id * 7 + c;
    endfunction

    task automatic load_tri(input int id, input int llx, input int lly, input int urx, input int ury);
        for (int v = 0; v < VERTS; v++)
            for (int a = 0; a < AXIS; a++)
                tri_R13S[v][a] = SIGFIG'(tri_val(id, v, a));
        for (int c = 0; c < COLORS; c++)
            color_R13U[c] = SIGFIG'(color_val(id, c));
        box_R13S[0][0] = SIGFIG'(llx);
        box_R13S[0][1] = SIGFIG'(lly);
        box_R13S[1][0] = SIGFIG'(urx);
        box_R13S[1][1] = SIGFIG'(ury);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        @(negedge clk);
        n_cmp++; if (halt_R13L !== 1'b0) begin n_err++; $display("FAIL reset_halt13: got %b want 0", halt_R13L); end
        n_cmp++; if (validSamp_R14H !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", validSamp_R14H); end
        n_cmp++; if (int'(sample_R14S[0]) !== 0 || int'(sample_R14S[1]) !== 0)
            begin n_err++; $display("FAIL reset_sample: got (%0d,%0d) want (0,0)", sample_R14S[0], sample_R14S[1]); end
        n_cmp++; if (int'(tri_R14S[1][2]) !== 0 || int'(color_R14U[0]) !== 0)
            begin n_err++; $display("FAIL reset_tri_color: got %0d/%0d want 0/0", tri_R14S[1][2], color_R14U[0]); end
        tick;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (halt_R13L !== 1'b1) begin n_err++; $display("FAIL reset_release_halt13: got %b want 1", halt_R13L); end
    endtask

    task automatic test_basic;
        int ex[4] = '{0, 1024, 0, 1024};
        int ey[4] = '{0, 0, 1024, 1024};
        tick;
        halt_RnnnnL = 1'b1; subSample_RnnnnU = 4'b1000;
        load_tri(1, 0, 0, 1024, 1024); validTri_R13H = 1'b1;
        @(negedge clk);
        n_cmp++; if (halt_R13L !== 1'b1) begin n_err++; $display("FAIL basic_ready: got %b want 1", halt_R13L); end
        tick;
        validTri_R13H = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++; if (validSamp_R14H !== 1'b1) begin n_err++; $display("FAIL basic_valid[%0d]: got %b want 1", i, validSamp_R14H); end
            n_cmp++; if (int'(sample_R14S[0]) !== ex[i] || int'(sample_R14S[1]) !== ey[i])
                begin n_err++; $display("FAIL basic_sample[%0d]: got (%0d,%0d) want (%0d,%0d)", i, sample_R14S[0], sample_R14S[1], ex[i], ey[i]); end
            n_cmp++; if (halt_R13L !== (i == 3)) begin n_err++; $display("FAIL basic_halt13[%0d]: got %b want %b", i, halt_R13L, (i == 3)); end
            n_cmp++; if (int'(tri_R14S[2][1]) !== tri_val(1, 2, 1) || int'(color_R14U[2]) !== color_val(1, 2))
                begin n_err++; $display("FAIL basic_tri_color[%0d]: got %0d/%0d want %0d/%0d", i, tri_R14S[2][1], color_R14U[2], tri_val(1, 2, 1), color_val(1, 2)); end
            tick;
        end
        @(negedge clk);
        n_cmp++; if (validSamp_R14H !== 1'b0) begin n_err++; $display("FAIL basic_done_valid: got %b want 0", validSamp_R14H); end
    endtask

    task automatic test_degenerate;
        tick;
        subSample_RnnnnU = 4'b0100;
        load_tri(2, 2048, 512, 2048, 512); validTri_R13H = 1'b1;
        tick;
        validTri_R13H = 1'b0;
        @(negedge clk);
        n_cmp++; if (validSamp_R14H !== 1'b1 || int'(sample_R14S[0]) !== 2048 || int'(sample_R14S[1]) !== 512)
            begin n_err++; $display("FAIL degen_sample: got v=%b (%0d,%0d) want v=1 (2048,512)", validSamp_R14H, sample_R14S[0], sample_R14S[1]); end
        n_cmp++; if (halt_R13L !== 1'b1) begin n_err++; $display("FAIL degen_halt13: got %b want 1", halt_R13L); end
        tick;
        @(negedge clk);
        n_cmp++; if (validSamp_R14H !== 1'b0) begin n_err++; $display("FAIL degen_done_valid: got %b want 0", validSamp_R14H); end
    endtask

    task automatic test_back_to_back;
        tick;
        halt_RnnnnL = 1'b1; subSample_RnnnnU = 4'b0100;
        load_tri(3, 0, 0, 512, 0); validTri_R13H = 1'b1;
        tick;
        subSample_RnnnnU = 4'b1000;
        load_tri(4, 1024, 1024, 1024, 1024); validTri_R13H = 1'b1;
        @(negedge clk);
        n_cmp++; if (int'(sample_R14S[0]) !== 0 || int'(sample_R14S[1]) !== 0 || int'(tri_R14S[0][0]) !== tri_val(3, 0, 0))
            begin n_err++; $display("FAIL b2b_first: got (%0d,%0d) tri %0d want (0,0) tri %0d", sample_R14S[0], sample_R14S[1], tri_R14S[0][0], tri_val(3, 0, 0)); end
        n_cmp++; if (halt_R13L !== 1'b0) begin n_err++; $display("FAIL b2b_halt13_first: got %b want 0", halt_R13L); end
        tick;
        @(negedge clk);
        n_cmp++; if (validSamp_R14H !== 1'b1 || int'(sample_R14S[0]) !== 512 || int'(sample_R14S[1]) !== 0)
            begin n_err++; $display("FAIL b2b_second: got v=%b (%0d,%0d) want v=1 (512,0)", validSamp_R14H, sample_R14S[0], sample_R14S[1]); end
        n_cmp++; if (halt_R13L !== 1'b1) begin n_err++; $display("FAIL b2b_halt13_last: got %b want 1", halt_R13L); end
        tick;
        validTri_R13H = 1'b0;
        @(negedge clk);
        n_cmp++; if (validSamp_R14H !== 1'b1 || int'(sample_R14S[0]) !== 1024 || int'(sample_R14S[1]) !== 1024)
            begin n_err++; $display("FAIL b2b_third: got v=%b (%0d,%0d) want v=1 (1024,1024)", validSamp_R14H, sample_R14S[0], sample_R14S[1]); end
        n_cmp++; if (int'(tri_R14S[0][0]) !== tri_val(4, 0, 0) || int'(color_R14U[1]) !== color_val(4, 1))
            begin n_err++; $display("FAIL b2b_tri_switch: got %0d/%0d want %0d/%0d", tri_R14S[0][0], color_R14U[1], tri_val(4, 0, 0), color_val(4, 1)); end
        tick;
        @(negedge clk);
        n_cmp++; if (validSamp_R14H !== 1'b0) begin n_err++; $display("FAIL b2b_done_valid: got %b want 0", validSamp_R14H); end
    endtask

    task automatic test_stall;
        tick;
        halt_RnnnnL = 1'b1; subSample_RnnnnU = 4'b1000;
        load_tri(5, 0, 0, 1024, 1024); validTri_R13H = 1'b1;
        tick;
        validTri_R13H = 1'b0;
        @(negedge clk);
        n_cmp++; if (int'(sample_R14S[0]) !== 0 || int'(sample_R14S[1]) !== 0)
            begin n_err++; $display("FAIL stall_first: got (%0d,%0d) want (0,0)", sample_R14S[0], sample_R14S[1]); end
        tick;
        halt_RnnnnL = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (validSamp_R14H !== 1'b1 || int'(sample_R14S[0]) !== 1024 || int'(sample_R14S[1]) !== 0 ||
                         int'(tri_R14S[1][1]) !== tri_val(5, 1, 1) || halt_R13L !== 1'b0)
                begin n_err++; $display("FAIL stall_hold[%0d]: got v=%b (%0d,%0d) h=%b want v=1 (1024,0) h=0", i, validSamp_R14H, sample_R14S[0], sample_R14S[1], halt_R13L); end
            tick;
        end
        halt_RnnnnL = 1'b1;
        @(negedge clk);
        n_cmp++; if (int'(sample_R14S[0]) !== 1024 || int'(sample_R14S[1]) !== 0)
            begin n_err++; $display("FAIL stall_release: got (%0d,%0d) want (1024,0)", sample_R14S[0], sample_R14S[1]); end
        tick;
        @(negedge clk);
        n_cmp++; if (int'(sample_R14S[0]) !== 0 || int'(sample_R14S[1]) !== 1024)
            begin n_err++; $display("FAIL stall_next: got (%0d,%0d) want (0,1024)", sample_R14S[0], sample_R14S[1]); end
        tick;
        @(negedge clk);
        n_cmp++; if (int'(sample_R14S[0]) !== 1024 || int'(sample_R14S[1]) !== 1024 || halt_R13L !== 1'b1)
            begin n_err++; $display("FAIL stall_last: got (%0d,%0d) h=%b want (1024,1024) h=1", sample_R14S[0], sample_R14S[1], halt_R13L); end
        tick;
        @(negedge clk);
        n_cmp++; if (validSamp_R14H !== 1'b0) begin n_err++; $display("FAIL stall_done_valid: got %b want 0", validSamp_R14H); end
    endtask

    task automatic test_reset_mid;
        tick;
        halt_RnnnnL = 1'b1; subSample_RnnnnU = 4'b1000;
        load_tri(6, 0, 0, 3072, 3072); validTri_R13H = 1'b1;
        tick;
        validTri_R13H = 1'b0;
        tick;
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (halt_R13L !== 1'b0) begin n_err++; $display("FAIL rstmid_halt13_in_rst: got %b want 0", halt_R13L); end
        tick;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (validSamp_R14H !== 1'b0 || int'(sample_R14S[0]) !== 0 || int'(sample_R14S[1]) !== 0 ||
                     int'(tri_R14S[2][2]) !== 0 || int'(color_R14U[2]) !== 0)
            begin n_err++; $display("FAIL rstmid_cleared: got v=%b (%0d,%0d) tri %0d want v=0 (0,0) tri 0", validSamp_R14H, sample_R14S[0], sample_R14S[1], tri_R14S[2][2]); end
        n_cmp++; if (halt_R13L !== 1'b1) begin n_err++; $display("FAIL rstmid_halt13_after: got %b want 1", halt_R13L); end
        tick;
        load_tri(7, -1024, 2048, 0, 2048); validTri_R13H = 1'b1;
        tick;
        validTri_R13H = 1'b0;
        @(negedge clk);
        n_cmp++; if (validSamp_R14H !== 1'b1 || int'(sample_R14S[0]) !== -1024 || int'(sample_R14S[1]) !== 2048)
            begin n_err++; $display("FAIL rstmid_new_first: got v=%b (%0d,%0d) want v=1 (-1024,2048)", validSamp_R14H, sample_R14S[0], sample_R14S[1]); end
        tick;
        @(negedge clk);
        n_cmp++; if (int'(sample_R14S[0]) !== 0 || int'(sample_R14S[1]) !== 2048)
            begin n_err++; $display("FAIL rstmid_new_second: got (%0d,%0d) want (0,2048)", sample_R14S[0], sample_R14S[1]); end
        tick;
        @(negedge clk);
        n_cmp++; if (validSamp_R14H !== 1'b0) begin n_err++; $display("FAIL rstmid_done_valid: got %b want 0", validSamp_R14H); end
    endtask

    task automatic test_overflow;
        int urx = (1 << (SIGFIG - 1)) - 1024;
        int llx = urx - 2048;
        int ury = urx;
        int lly = ury - 1024;
        int qx[$];
        int qy[$];
        int cnt = 0;
        int want_cnt = ((urx - llx) / 1024 + 1) * ((ury - lly) / 1024 + 1);
        for (int y = lly; y <= ury; y += 1024)
            for (int x = llx; x <= urx; x += 1024) begin
                qx.push_back(x);
                qy.push_back(y);
            end
        tick;
        halt_RnnnnL = 1'b1; subSample_RnnnnU = 4'b1000;
        load_tri(8, llx, lly, urx, ury); validTri_R13H = 1'b1;
        tick;
        validTri_R13H = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (validSamp_R14H === 1'b1) begin
                if (cnt < qx.size()) begin
                    n_cmp++; if (int'(sample_R14S[0]) !== qx[cnt] || int'(sample_R14S[1]) !== qy[cnt])
                        begin n_err++; $display("FAIL ovf_sample[%0d]: got (%0d,%0d) want (%0d,%0d)", cnt, sample_R14S[0], sample_R14S[1], qx[cnt], qy[cnt]); end
                end
                cnt++;
            end
            tick;
        end
        n_cmp++; if (cnt !== want_cnt) begin n_err++; $display("FAIL ovf_count: got %0d want %0d", cnt, want_cnt); end
    endtask

    task automatic test_random;
        int qx[$];
        int qy[$];
        int qid[$];
        bit pend = 1'b0;
        int id = 100;
        int p_llx, p_lly, p_urx, p_ury;
        int step;
        bit exp_halt;
        tick;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!pend && cyc < 2500 && $urandom_range(0, 3) == 0) begin
                id++;
                p_llx = int'($urandom_range(0, 64)) * 128 - 4096;
                p_lly = int'($urandom_range(0, 64)) * 128 - 4096;
                p_urx = p_llx + int'($urandom_range(0, 2)) * 1024;
                p_ury = p_lly + int'($urandom_range(0, 2)) * 1024;
                load_tri(id, p_llx, p_lly, p_urx, p_ury);
                validTri_R13H = 1'b1;
                pend = 1'b1;
            end
            halt_RnnnnL = (cyc >= 2500) ? 1'b1 : ($urandom_range(0, 3) != 0);
            subSample_RnnnnU = 4'b1000 >> $urandom_range(0, 3);
            @(negedge clk);
            exp_halt = (qx.size() == 0) || (qx.size() == 1 && halt_RnnnnL);
            n_cmp++; if (halt_R13L !== exp_halt) begin n_err++; $display("FAIL rand_halt13 @%0d: got %b want %b", cyc, halt_R13L, exp_halt); end
            n_cmp++; if (validSamp_R14H !== (qx.size() != 0)) begin n_err++; $display("FAIL rand_valid @%0d: got %b want %b", cyc, validSamp_R14H, (qx.size() != 0)); end
            if (qx.size() != 0) begin
                n_cmp++; if (int'(sample_R14S[0]) !== qx[0] || int'(sample_R14S[1]) !== qy[0] ||
                             int'(tri_R14S[2][2]) !== tri_val(qid[0], 2, 2) || int'(color_R14U[0]) !== color_val(qid[0], 0))
                    begin n_err++; $display("FAIL rand_sample @%0d: got (%0d,%0d) tri %0d want (%0d,%0d) tri %0d", cyc, sample_R14S[0], sample_R14S[1], tri_R14S[2][2], qx[0], qy[0], tri_val(qid[0], 2, 2)); end
                if (halt_RnnnnL) begin
                    void'(qx.pop_front());
                    void'(qy.pop_front());
                    void'(qid.pop_front());
                end
            end
            if (exp_halt && validTri_R13H) begin
                case (subSample_RnnnnU)
                    4'b1000: step = 1024;
                    4'b0100: step = 512;
                    4'b0010: step = 256;
                    default: step = 128;
                endcase
                for (int y = p_lly; y <= p_ury; y += step)
                    for (int x = p_llx; x <= p_urx; x += step) begin
                        qx.push_back(x);
                        qy.push_back(y);
                        qid.push_back(id);
                    end
                pend = 1'b0;
            end
            tick;
            if (!pend) validTri_R13H = 1'b0;
        end
        @(negedge clk);
        n_cmp++; if (qx.size() != 0 || validSamp_R14H !== 1'b0)
            begin n_err++; $display("FAIL rand_drain: got %0d samples pending, valid=%b want 0, 0", qx.size(), validSamp_R14H); end
    endtask

    initial begin
        rst              = 1'b1;
        validTri_R13H    = 1'b0;
        halt_RnnnnL      = 1'b1;
        subSample_RnnnnU = 4'b1000;
        load_tri(0, 0, 0, 0, 0);
        test_reset;
        test_basic;
        test_degenerate;
        test_back_to_back;
        test_stall;
        test_reset_mid;
        test_overflow;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
